// File: rtl/nios_hex_display.sv
// nios_hex_display: Avalon-MM 7-segment bank (clk/reset; address, chipselect, write_n, read_n, writedata -> readdata; seg_out gfedcba per digit) with decode, blank and blink
module nios_hex_display #(
  parameter int          NUM_DIGITS     = 6,
  parameter int          CNT_W          = 26,
  parameter int unsigned PRESCALE_RST   = 24999999,
  parameter bit          SEG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic                    read_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [7*NUM_DIGITS-1:0] seg_out
);
  localparam int SW = 7*NUM_DIGITS;
  localparam logic [7:0] DMASK = 8'((9'd1 << NUM_DIGITS) - 9'd1);
  localparam logic [SW-1:0] SEG_OFF = {SW{SEG_ACTIVE_LOW}};
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic             wr, rd, tc, ps_wr;
  logic [6:0]       digit_q [8];
  logic [6:0]       digit_d [8];
  logic [7:0]       dec_q, dec_d, blank_q, blank_d, blink_q, blink_d;
  logic [CNT_W-1:0] prescale_q, prescale_d, cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [SW-1:0]    seg_q, seg_d;
  always_comb begin
    wr = chipselect && !write_n;
    rd = chipselect && !read_n;
    tc = cnt_q == prescale_q;
    ps_wr = wr && address == 4'd10;
    for (int i = 0; i < 8; i++)
      digit_d[i] = (wr && address == 4'(i) && i < NUM_DIGITS) ? writedata[6:0] : digit_q[i];
    dec_d      = (wr && address == 4'd8) ? writedata[7:0] & DMASK : dec_q;
    blank_d    = (wr && address == 4'd8) ? writedata[15:8] & DMASK : blank_q;
    blink_d    = (wr && address == 4'd9) ? writedata[7:0] & DMASK : blink_q;
    prescale_d = ps_wr ? writedata[CNT_W-1:0] : prescale_q;
    cnt_d      = (ps_wr || tc) ? '0 : cnt_q + 1'b1;
    phase_d    = ps_wr ? 1'b0 : phase_q ^ tc;
    readdata_d = !rd                ? readdata_q :
                 address < 4'd8     ? {25'd0, digit_q[address[2:0]]} :
                 address == 4'd8    ? {16'd0, blank_q, dec_q} :
                 address == 4'd9    ? {24'd0, blink_q} :
                 address == 4'd10   ? 32'(prescale_q) :
                 address == 4'd11   ? {31'd0, phase_q} : 32'd0;
    seg_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      seg_d[7*i +: 7] = {7{SEG_ACTIVE_LOW}} ^
        ((blank_q[i] || (blink_q[i] && phase_q)) ? 7'd0 :
         dec_q[i] ? HEX[digit_q[i][3:0]] : digit_q[i]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q    <= '{default: '0};
      dec_q      <= '0;
      blank_q    <= '0;
      blink_q    <= '0;
      prescale_q <= CNT_W'(PRESCALE_RST);
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      readdata_q <= '0;
      seg_q      <= SEG_OFF;
    end else begin
      digit_q    <= digit_d;
      dec_q      <= dec_d;
      blank_q    <= blank_d;
      blink_q    <= blink_d;
      prescale_q <= prescale_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      readdata_q <= readdata_d;
      seg_q      <= seg_d;
    end
  end
  assign readdata = readdata_q;
  assign seg_out  = seg_q;
endmodule
